// File: rtl/sd_tx_gigmac_pkg.sv
// rtl/sd_tx_gigmac_pkg.sv - packet codes, GMII constants and TX FSM states shared with the RX MAC
package sd_tx_gigmac_pkg;

   localparam logic [1:0]  PCC_DATA      = 2'b00;
   localparam logic [1:0]  PCC_SOP       = 2'b01;
   localparam logic [1:0]  PCC_EOP       = 2'b10;
   localparam logic [1:0]  PCC_BADEOP    = 2'b11;

   localparam logic [7:0]  GMII_SFD      = 8'hD5;
   localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
   localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
   localparam logic [15:0] PREAMBLE_LEN  = 16'd7;

   typedef enum logic [6:0] {
      S_IDLE     = 7'b000_0001,
      S_PREAMBLE = 7'b000_0010,
      S_PAYLOAD  = 7'b000_0100,
      S_PAD      = 7'b000_1000,
      S_FCS      = 7'b001_0000,
      S_FLUSH    = 7'b010_0000,
      S_IFG      = 7'b100_0000
   } tx_state_e;

   function automatic logic is_eop(input logic [1:0] code);
      return (code == PCC_EOP) || (code == PCC_BADEOP);
   endfunction

endpackage

// File: rtl/sd_crc32_byte.sv
// rtl/sd_crc32_byte.sv - byte-wide CRC32 step (data LSB first) and the reflected, complemented FCS
module sd_crc32_byte
   import sd_tx_gigmac_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out,
   output logic [31:0] fcs
);

   always_comb begin
      crc_out = crc_in;
      for (int i = 0; i < 8; i++) begin
         crc_out = {crc_out[30:0], 1'b0} ^ ((crc_out[31] ^ data[i]) ? CRC32_POLY : 32'd0);
      end
      fcs = '0;
      for (int i = 0; i < 32; i++) begin
         fcs[i] = ~crc_in[31-i];
      end
   end

endmodule

// File: rtl/sd_tx_gigmac.sv
// rtl/sd_tx_gigmac.sv - GMII transmit MAC: preamble/SFD, padding, FCS, abort handling and IFG
module sd_tx_gigmac
   import sd_tx_gigmac_pkg::*;
#(
   parameter int IFG_CYCLES = 12,
   parameter int MIN_FRAME  = 60,
   parameter bit PAD_EN     = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       txg_srdy,
   output logic       txg_drdy,
   input  logic [1:0] txg_code,
   input  logic [7:0] txg_data,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic [7:0] gmii_txd,
   output logic       tx_done,
   output logic       tx_abort
);

   localparam logic [15:0] IFG_LAST  = 16'(IFG_CYCLES - 1);
   localparam logic [11:0] MIN_FRM_W = 12'(MIN_FRAME);

   tx_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [10:0] byte_cnt_q, byte_cnt_d;
   logic [31:0] crc_q, crc_d;
   logic        bad_q, bad_d;
   logic        tx_en_q, tx_en_d;
   logic        tx_er_q, tx_er_d;
   logic [7:0]  txd_q, txd_d;
   logic        tx_done_q, tx_done_d;
   logic        tx_abort_q, tx_abort_d;

   logic [31:0] crc_nxt, fcs_w;
   logic [7:0]  crc_byte;
   logic [10:0] byte_inc;
   logic [11:0] byte_nxt12;
   logic        is_sop, is_end, first_byte;

   assign is_sop     = (txg_code == PCC_SOP);
   assign is_end     = is_eop(txg_code);
   assign first_byte = (byte_cnt_q == 11'd0);
   assign byte_inc   = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
   assign byte_nxt12 = {1'b0, byte_cnt_q} + 12'd1;
   assign crc_byte   = (state_q == S_PAD) ? 8'h00 : txg_data;

   sd_crc32_byte u_crc (
      .crc_in  (crc_q),
      .data    (crc_byte),
      .crc_out (crc_nxt),
      .fcs     (fcs_w)
   );

   // An SOP is only consumed as the first payload byte; later ones stay at the input.
   always_comb begin
      txg_drdy = 1'b0;
      case (state_q)
         S_IDLE:    txg_drdy = !is_sop;
         S_PAYLOAD: txg_drdy = first_byte || !is_sop;
         S_FLUSH:   txg_drdy = !is_sop;
         default:   txg_drdy = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      byte_cnt_d = byte_cnt_q;
      crc_d      = crc_q;
      bad_d      = bad_q;
      tx_en_d    = 1'b0;
      tx_er_d    = 1'b0;
      txd_d      = 8'h00;
      tx_done_d  = 1'b0;
      tx_abort_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            crc_d      = '1;
            byte_cnt_d = '0;
            bad_d      = 1'b0;
            cnt_d      = '0;
            if (txg_srdy && is_sop) begin
               state_d = S_PREAMBLE;
               tx_en_d = 1'b1;
               txd_d   = GMII_PREAMBLE;
               cnt_d   = 16'd1;
            end
         end
         S_PREAMBLE: begin
            tx_en_d = 1'b1;
            if (cnt_q == PREAMBLE_LEN) begin
               txd_d   = GMII_SFD;
               state_d = S_PAYLOAD;
            end else begin
               txd_d = GMII_PREAMBLE;
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_PAYLOAD: begin
            tx_en_d = 1'b1;
            if (!txg_srdy) begin
               tx_er_d    = 1'b1;
               tx_abort_d = 1'b1;
               state_d    = S_FLUSH;
            end else if (is_sop && !first_byte) begin
               tx_er_d    = 1'b1;
               tx_abort_d = 1'b1;
               state_d    = S_IFG;
               cnt_d      = '0;
            end else begin
               txd_d      = txg_data;
               crc_d      = crc_nxt;
               byte_cnt_d = byte_inc;
               if (is_end) begin
                  bad_d   = (txg_code == PCC_BADEOP);
                  cnt_d   = '0;
                  state_d = (PAD_EN && (byte_nxt12 < MIN_FRM_W)) ? S_PAD : S_FCS;
               end
            end
         end
         S_PAD: begin
            tx_en_d    = 1'b1;
            crc_d      = crc_nxt;
            byte_cnt_d = byte_inc;
            if (byte_nxt12 >= MIN_FRM_W) begin
               state_d = S_FCS;
               cnt_d   = '0;
            end
         end
         S_FCS: begin
            tx_en_d = 1'b1;
            tx_er_d = bad_q;
            txd_d   = fcs_w[{cnt_q[1:0], 3'b000} +: 8];
            if (cnt_q[1:0] == 2'd3) begin
               tx_done_d = 1'b1;
               state_d   = S_IFG;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_FLUSH: begin
            if (txg_srdy && (is_sop || is_end)) begin
               state_d = S_IFG;
               cnt_d   = '0;
            end
         end
         S_IFG: begin
            if (cnt_q >= IFG_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         byte_cnt_q <= '0;
         crc_q      <= '1;
         bad_q      <= 1'b0;
         tx_en_q    <= 1'b0;
         tx_er_q    <= 1'b0;
         txd_q      <= 8'h00;
         tx_done_q  <= 1'b0;
         tx_abort_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         byte_cnt_q <= byte_cnt_d;
         crc_q      <= crc_d;
         bad_q      <= bad_d;
         tx_en_q    <= tx_en_d;
         tx_er_q    <= tx_er_d;
         txd_q      <= txd_d;
         tx_done_q  <= tx_done_d;
         tx_abort_q <= tx_abort_d;
      end
   end

   assign gmii_tx_en = tx_en_q;
   assign gmii_tx_er = tx_er_q;
   assign gmii_txd   = txd_q;
   assign tx_done    = tx_done_q;
   assign tx_abort   = tx_abort_q;

endmodule
